// File: rtl/counter_pkg.sv
// Shared constants and helpers for the synchronous modulo counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // True when a parallel-load value lies outside 0..max_val and must be clamped.
  function automatic logic exceeds_max(input logic [31:0] val, input logic [31:0] max_val);
    return (val > max_val);
  endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational single-step logic: next count plus end-of-range and wrap flags.
module counter_step
  import counter_pkg::*;
#(
  parameter int NBIT    = 4,
  parameter int MAX_VAL = 2**NBIT-1
) (
  input  logic [NBIT-1:0] q,
  input  logic            dir,
  input  logic            sat_mode,
  output logic [NBIT-1:0] q_next,
  output logic            at_end,
  output logic            wrap_next
);

  // One extra bit keeps MAX_VAL = 2**NBIT-1 from aliasing on increment.
  localparam logic [NBIT:0] MAX_EXT = (NBIT+1)'(MAX_VAL);

  logic [NBIT:0] q_ext;
  logic [NBIT:0] sum_ext;

  assign q_ext = {1'b0, q};

  always_comb begin
    sum_ext   = q_ext;
    at_end    = 1'b0;
    wrap_next = 1'b0;
    if (dir == DIR_UP) begin
      if (q_ext == MAX_EXT) begin
        at_end = 1'b1;
        if (sat_mode == MODE_WRAP) begin
          sum_ext   = '0;
          wrap_next = 1'b1;
        end
      end else begin
        sum_ext = q_ext + 1'b1;
      end
    end else begin
      if (q_ext == '0) begin
        at_end = 1'b1;
        if (sat_mode == MODE_WRAP) begin
          sum_ext   = MAX_EXT;
          wrap_next = 1'b1;
        end
      end else begin
        sum_ext = q_ext - 1'b1;
      end
    end
  end

  assign q_next = sum_ext[NBIT-1:0];

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous up/down modulo counter with load, set, wrap/saturate and cascade tc.
// Optional sticky overflow flag enabled by defining SYNC_MOD_COUNTER_OVF_STICKY_EN.
module sync_mod_counter
  import counter_pkg::*;
#(
  parameter int NBIT    = 4,
  parameter int MAX_VAL = 2**NBIT-1,
  parameter int RST_VAL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            set_signal,
  input  logic            load,
  input  logic [NBIT-1:0] load_val,
  input  logic            dir,
  input  logic            sat_mode,
`ifdef SYNC_MOD_COUNTER_OVF_STICKY_EN
  input  logic            ovf_clr,
  output logic            ovf,
`endif
  output logic [NBIT-1:0] Q,
  output logic            tc,
  output logic            wrap
);

  generate
    if (NBIT < 1 || MAX_VAL < 1 || MAX_VAL > (2**NBIT)-1 || RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_bad_params
      $error("sync_mod_counter: illegal NBIT/MAX_VAL/RST_VAL combination");
    end
  endgenerate

  localparam logic [NBIT-1:0] MAX_Q = NBIT'(MAX_VAL);
  localparam logic [NBIT-1:0] RST_Q = NBIT'(RST_VAL);

  logic [NBIT-1:0] q_q, q_d;
  logic            wrap_q, wrap_d;
  logic [NBIT-1:0] step_q;
  logic            step_at_end;
  logic            step_wrap;

  counter_step #(
    .NBIT    (NBIT),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .q         (q_q),
    .dir       (dir),
    .sat_mode  (sat_mode),
    .q_next    (step_q),
    .at_end    (step_at_end),
    .wrap_next (step_wrap)
  );

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (set_signal) begin
      q_d = MAX_Q;
    end else if (load) begin
      q_d = exceeds_max(32'(load_val), 32'(MAX_VAL)) ? MAX_Q : load_val;
    end else if (en) begin
      q_d    = step_q;
      wrap_d = step_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef SYNC_MOD_COUNTER_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  // A step attempted at the range end either wraps or is blocked by saturation; set beats clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (!set_signal && !load && en && step_at_end) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign Q    = q_q;
  assign wrap = wrap_q;
  assign tc   = en & step_at_end;

endmodule

// File: tb/tb_sync_mod_counter.sv
// Directed self-checking bench for sync_mod_counter (NBIT=4, MAX_VAL=9) plus a two-digit cascade.
module tb_sync_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, set_signal, load, dir, sat_mode;
  logic [3:0] load_val;
  logic [3:0] Q;
  logic       tc, wrap;
`ifdef SYNC_MOD_COUNTER_OVF_STICKY_EN
  logic       ovf_clr, ovf;
`endif

  logic       c_rst;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_mod_counter #(.NBIT(4), .MAX_VAL(9), .RST_VAL(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .set_signal (set_signal),
    .load       (load),
    .load_val   (load_val),
    .dir        (dir),
    .sat_mode   (sat_mode),
`ifdef SYNC_MOD_COUNTER_OVF_STICKY_EN
    .ovf_clr    (ovf_clr),
    .ovf        (ovf),
`endif
    .Q          (Q),
    .tc         (tc),
    .wrap       (wrap)
  );

  sync_mod_counter #(.NBIT(4), .MAX_VAL(9), .RST_VAL(0)) u_lo (
    .clk        (clk),
    .rst        (c_rst),
    .en         (1'b1),
    .set_signal (1'b0),
    .load       (1'b0),
    .load_val   (4'd0),
    .dir        (1'b1),
    .sat_mode   (1'b0),
`ifdef SYNC_MOD_COUNTER_OVF_STICKY_EN
    .ovf_clr    (1'b0),
    .ovf        (),
`endif
    .Q          (lo_q),
    .tc         (lo_tc),
    .wrap       (lo_wrap)
  );

  sync_mod_counter #(.NBIT(4), .MAX_VAL(9), .RST_VAL(0)) u_hi (
    .clk        (clk),
    .rst        (c_rst),
    .en         (lo_tc),
    .set_signal (1'b0),
    .load       (1'b0),
    .load_val   (4'd0),
    .dir        (1'b1),
    .sat_mode   (1'b0),
`ifdef SYNC_MOD_COUNTER_OVF_STICKY_EN
    .ovf_clr    (1'b0),
    .ovf        (),
`endif
    .Q          (hi_q),
    .tc         (hi_tc),
    .wrap       (hi_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %-14s obs=%0d exp=%0d ok", tag, obs, exp);
    end else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sat[4];
    int wrap_cnt;
    exp_sat = '{8, 9, 9, 9};

    rst = 1'b1; en = 1'b0; set_signal = 1'b0; load = 1'b0; load_val = 4'd0;
    dir = 1'b1; sat_mode = 1'b0; c_rst = 1'b1;
`ifdef SYNC_MOD_COUNTER_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    step();
    chk("rst_q", 32'(Q), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_tc", 32'(tc), 0);

    // Wrap-mode count-up through 9 -> 0
    rst = 1'b0; en = 1'b1; dir = 1'b1; sat_mode = 1'b0;
    #1;
    chk("up_tc0", 32'(tc), 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("up_q", 32'(Q), 32'(i % 10));
      chk("up_wrap", 32'(wrap), (i == 10) ? 1 : 0);
      chk("up_tc", 32'(tc), ((i % 10) == 9) ? 1 : 0);
    end

    // Saturate up from 7, then count down
    load = 1'b1; load_val = 4'd7;
    step();
    chk("ld7_q", 32'(Q), 7);
    load = 1'b0; sat_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sat_q", 32'(Q), 32'(exp_sat[i]));
      chk("sat_wrap", 32'(wrap), 0);
      chk("sat_tc", 32'(tc), (exp_sat[i] == 9) ? 1 : 0);
    end
    dir = 1'b0;
    step();
    chk("dn_q8", 32'(Q), 8);
    step();
    chk("dn_q7", 32'(Q), 7);
    chk("dn_tc", 32'(tc), 0);

    // Down wrap from 0
    load = 1'b1; load_val = 4'd0; sat_mode = 1'b0;
    step();
    load = 1'b0;
    #1;
    chk("ld0_q", 32'(Q), 0);
    chk("dn0_tc", 32'(tc), 1);
    step();
    chk("dnwrap_q", 32'(Q), 9);
    chk("dnwrap_pulse", 32'(wrap), 1);
    en = 1'b0;
    step();
    chk("dnwrap_end", 32'(wrap), 0);

    // Load clamp and normal load
    load = 1'b1; load_val = 4'd12;
    step();
    chk("ld_clamp", 32'(Q), 9);
    load_val = 4'd5;
    step();
    chk("ld5_q", 32'(Q), 5);

    // Priority: rst > set > load > en
    rst = 1'b1; set_signal = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'd3;
    step();
    chk("prio_rst", 32'(Q), 0);
    rst = 1'b0;
    step();
    chk("prio_set", 32'(Q), 9);
    set_signal = 1'b0; load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_q", 32'(Q), 9);
      chk("hold_wrap", 32'(wrap), 0);
    end
    chk("hold_tc", 32'(tc), 0);

`ifdef SYNC_MOD_COUNTER_OVF_STICKY_EN
    rst = 1'b1;
    step();
    chk("ovf_rst", 32'(ovf), 0);
    rst = 1'b0; load = 1'b1; load_val = 4'd9; dir = 1'b1; sat_mode = 1'b0;
    step();
    chk("ovf_pre", 32'(ovf), 0);
    load = 1'b0; en = 1'b1;
    step();
    chk("ovf_set", 32'(ovf), 1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ovf_sticky", 32'(ovf), 1);
    end
    load = 1'b1;
    step();
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
    step();
    chk("ovf_setwins", 32'(ovf), 1);
    en = 1'b0;
    step();
    chk("ovf_clr", 32'(ovf), 0);
    ovf_clr = 1'b0;
`endif

    // Two-digit cascade: 100 edges returns to 00 with one hi wrap pulse
    c_rst = 1'b1;
    step();
    chk("cas_rst", 32'({hi_q, lo_q}), 0);
    c_rst = 1'b0;
    wrap_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (hi_wrap) wrap_cnt++;
    end
    chk("cas_lo", 32'(lo_q), 0);
    chk("cas_hi", 32'(hi_q), 0);
    chk("cas_hiwrap", 32'(wrap_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
